regfile_sb: RTL

- Parametrised successor to the 8x8 CPU register file: configurable data width and register count.
- Adds write-to-read bypass, a per-register busy scoreboard for in-flight writes, and a sequenced post-reset clear of all registers.
- Sits between decode (read/reserve) and writeback (write) in the pipelined datapath.
- Register 0 is hardwired to zero.

---
 rtl/regfile_sb_pkg.sv | 23 ++
 rtl/regfile_sb_if.sv | 43 ++++
 rtl/regfile_sb_score.sv | 60 ++++++
 rtl/regfile_sb.sv | 116 +++++++++++
 4 files changed

// File: rtl/regfile_sb_pkg.sv
`default_nettype none
// ============================================================================
// Module      : regfile_pkg
// Description : Shared definitions for the scoreboarded register file:
//               clear/run state encoding, the hardwired-zero register
//               address and the default datapath geometry.
// Revision    : 1.0 - initial release
// ============================================================================
package regfile_pkg;

    localparam int c_DEF_DW   = 8;
    localparam int c_DEF_NREG = 8;

    // Register 0 always reads as zero; writes and reservations to it are dropped.
    localparam int ZERO_REG = 0;

    typedef enum logic [0:0] {
        ST_CLEAR = 1'b0,
        ST_RUN   = 1'b1
    } state_t;

endpackage
`default_nettype wire

// File: rtl/regfile_sb_if.sv
`default_nettype none
// ============================================================================
// Module      : regfile_sb_if
// Description : Decode/writeback bus of the scoreboarded register file.
//               master : pipeline side (drives write, read and reserve)
//               slave  : register file (returns read data, busy bits, ready)
// Ports       : ready, regwrite/wa/wd, ra1/ra2, rd1/rd2, res_en/res_addr,
//               busy1/busy2
// Revision    : 1.0 - initial release
// ============================================================================
interface regfile_sb_if
    import regfile_pkg::*;
#(
    parameter int DW   = c_DEF_DW,
    parameter int NREG = c_DEF_NREG
);
    localparam int AW = $clog2(NREG);

    logic          ready;
    logic          regwrite;
    logic [AW-1:0] wa;
    logic [DW-1:0] wd;
    logic [AW-1:0] ra1;
    logic [AW-1:0] ra2;
    logic [DW-1:0] rd1;
    logic [DW-1:0] rd2;
    logic          res_en;
    logic [AW-1:0] res_addr;
    logic          busy1;
    logic          busy2;

    modport master (
        output regwrite, wa, wd, ra1, ra2, res_en, res_addr,
        input  ready, rd1, rd2, busy1, busy2
    );

    modport slave (
        input  regwrite, wa, wd, ra1, ra2, res_en, res_addr,
        output ready, rd1, rd2, busy1, busy2
    );

endinterface
`default_nettype wire

// File: rtl/regfile_sb_score.sv
`default_nettype none
// ============================================================================
// Module      : regfile_sb_score
// Description : Busy scoreboard for in-flight register writes. A reservation
//               sets a register's busy bit, a writeback clears it; when both
//               hit the same register in one cycle the reservation wins.
//               The busy outputs are released combinationally by a
//               same-cycle write to the read address, matching the bypass.
// Ports       : clk, rst         - clock, synchronous active-high reset
//               i_en             - file is in RUN (gates all activity)
//               i_we, i_wa       - writeback enable/address
//               i_res_en/addr    - reservation request
//               i_ra1, i_ra2     - read addresses
//               o_busy1, o_busy2 - hazard flags for the read addresses
// Revision    : 1.0 - initial release
// ============================================================================
module regfile_sb_score
#(
    parameter int NREG = 8,
    parameter int AW   = $clog2(NREG)
) (
    input  wire logic          clk,
    input  wire logic          rst,
    input  wire logic          i_en,
    input  wire logic          i_we,
    input  wire logic [AW-1:0] i_wa,
    input  wire logic          i_res_en,
    input  wire logic [AW-1:0] i_res_addr,
    input  wire logic [AW-1:0] i_ra1,
    input  wire logic [AW-1:0] i_ra2,
    output logic               o_busy1,
    output logic               o_busy2
);

    // Bit 0 is only ever written by reset, so it stays constant 0.
    logic [NREG-1:0] r_busy;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_busy <= '0;
        end else if (i_en) begin
            for (int i = 1; i < NREG; i++) begin
                // Reservation is checked first: it belongs to a younger
                // instruction than the write retiring this cycle.
                if (i_res_en && i_res_addr == AW'(i)) begin
                    r_busy[i] <= 1'b1;
                end else if (i_we && i_wa == AW'(i)) begin
                    r_busy[i] <= 1'b0;
                end
            end
        end
    end

    always_comb begin
        o_busy1 = i_en && r_busy[i_ra1] && !(i_we && i_wa == i_ra1);
        o_busy2 = i_en && r_busy[i_ra2] && !(i_we && i_wa == i_ra2);
    end

endmodule
`default_nettype wire

// File: rtl/regfile_sb.sv
`default_nettype none
// ============================================================================
// Module      : regfile_sb
// Description : Parametrised register file with same-cycle write-to-read
//               bypass, per-register busy scoreboard and a sequenced
//               post-reset clear. Register 0 reads as zero.
//               After reset the file walks registers 1..NREG-1 writing 0,
//               one per cycle, and raises ready when done (NREG-1 cycles).
// Ports       : clk  - clock
//               rst  - synchronous active-high reset (restarts the clear)
//               bus  - regfile_sb_if slave: ready, write port, two
//                      combinational read ports, reserve port, busy flags
// Revision    : 1.0 - initial release
// ============================================================================
module regfile_sb
    import regfile_pkg::*;
#(
    parameter int DW   = c_DEF_DW,
    parameter int NREG = c_DEF_NREG,
    localparam int AW  = $clog2(NREG)
) (
    input  wire logic   clk,
    input  wire logic   rst,
    regfile_sb_if.slave bus
);

    state_t          r_state;
    logic [AW-1:0]   r_cnt;
    logic            r_ready;
    logic [DW-1:0]   r_regs [NREG];

    logic            w_run;
    logic            w_wr;
    logic [DW-1:0]   w_rd1;
    logic [DW-1:0]   w_rd2;

    assign w_run = (r_state == ST_RUN);
    assign w_wr  = w_run && bus.regwrite && (bus.wa != AW'(ZERO_REG));

    // Clear FSM and storage. Entry 0 is never written or read.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_CLEAR;
            r_cnt   <= AW'(1);
            r_ready <= 1'b0;
        end else begin
            case (r_state)
                ST_CLEAR: begin
                    r_regs[r_cnt] <= '0;
                    r_cnt         <= r_cnt + AW'(1);
                    if (r_cnt == AW'(NREG - 1)) begin
                        r_state <= ST_RUN;
                        r_ready <= 1'b1;
                    end
                end
                ST_RUN: begin
                    if (w_wr) begin
                        r_regs[bus.wa] <= bus.wd;
                    end
                end
                default: begin
                    r_state <= ST_CLEAR;
                    r_cnt   <= AW'(1);
                    r_ready <= 1'b0;
                end
            endcase
        end
    end

    // Read ports: zero register, then same-cycle bypass, then storage.
    // Everything reads zero while the clear is in progress.
    always_comb begin
        w_rd1 = '0;
        if (w_run && bus.ra1 != AW'(ZERO_REG)) begin
            if (bus.regwrite && bus.wa == bus.ra1) begin
                w_rd1 = bus.wd;
            end else begin
                w_rd1 = r_regs[bus.ra1];
            end
        end
    end

    always_comb begin
        w_rd2 = '0;
        if (w_run && bus.ra2 != AW'(ZERO_REG)) begin
            if (bus.regwrite && bus.wa == bus.ra2) begin
                w_rd2 = bus.wd;
            end else begin
                w_rd2 = r_regs[bus.ra2];
            end
        end
    end

    assign bus.rd1   = w_rd1;
    assign bus.rd2   = w_rd2;
    assign bus.ready = r_ready;

    regfile_sb_score #(
        .NREG (NREG),
        .AW   (AW)
    ) u_score (
        .clk        (clk),
        .rst        (rst),
        .i_en       (w_run),
        .i_we       (bus.regwrite),
        .i_wa       (bus.wa),
        .i_res_en   (bus.res_en),
        .i_res_addr (bus.res_addr),
        .i_ra1      (bus.ra1),
        .i_ra2      (bus.ra2),
        .o_busy1    (bus.busy1),
        .o_busy2    (bus.busy2)
    );

endmodule
`default_nettype wire
